// File: rtl/hash_io_pkg.sv
// hash_io_pkg: shared widths, derived word counts and state encoding
// for the hash core host responder.
package hash_io_pkg;
    localparam int IO_W  = 16;
    localparam int BLK_W = 512;
    localparam int DIG_W = 256;
    localparam int WPB   = BLK_W / IO_W;
    localparam int WPD   = DIG_W / IO_W;
    typedef enum logic [2:0] {IDLE, LOAD, HAND, HASH, OUT} state_t;
endpackage

// File: rtl/hash_io_responder_sipo.sv
// hash_io_responder_sipo: word-indexed block buffer, word 0 in the top IO_W bits.
module hash_io_responder_sipo #(
    parameter int IO_W  = 16,
    parameter int BLK_W = 512,
    parameter int IW    = $clog2(BLK_W / IO_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [IO_W-1:0]  wdata,
    output logic [BLK_W-1:0] data
);
    localparam int N = BLK_W / IO_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else if (we) data[IO_W*(N-1-int'(idx)) +: IO_W] <= wdata;
    end
endmodule

// File: rtl/hash_io_responder.sv
// hash_io_responder: host-side word-serial init/load/fetch/ack responder
// that assembles blocks for the hash core and returns the final digest.
module hash_io_responder #(
    parameter int IO_W  = hash_io_pkg::IO_W,
    parameter int BLK_W = hash_io_pkg::BLK_W,
    parameter int DIG_W = hash_io_pkg::DIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             load,
    input  logic             fetch,
    input  logic [IO_W-1:0]  idata,
    input  logic             EOM,
    output logic             ack,
    output logic [IO_W-1:0]  odata,
    output logic             err,
    output logic             core_init,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid,
    output logic             blk_last,
    input  logic             blk_ready,
    input  logic             core_done,
    input  logic [DIG_W-1:0] digest
);
    import hash_io_pkg::*;

    localparam int NB  = BLK_W / IO_W;
    localparam int ND  = DIG_W / IO_W;
    localparam int WCW = $clog2(NB);
    localparam int FCW = $clog2(ND);

    state_t state, state_n;
    logic [WCW-1:0] wcnt;
    logic [FCW-1:0] fcnt;
    logic [DIG_W-1:0] dig_buf;
    logic ld_acc, fe_acc, wr_last, latch, stray;

    hash_io_responder_sipo #(.IO_W(IO_W), .BLK_W(BLK_W), .IW(WCW)) u_sipo (
        .clk(clk), .rst_n(rst_n), .we(ld_acc), .idx(wcnt), .wdata(idata), .data(blk_data)
    );

    assign blk_valid = state == HAND;

    // init pre-empts every accept, error and core_done in the same cycle
    always_comb begin
        ld_acc  = !init && load && !ack && state == LOAD;
        fe_acc  = !init && fetch && !ack && state == OUT;
        wr_last = ld_acc && wcnt == WCW'(NB - 1);
        latch   = !init && state == HASH && core_done && blk_last;
        stray   = !init && !ack && ((load && state != LOAD) || (fetch && state != OUT));
        state_n = state;
        if (init) state_n = LOAD;
        else begin
            case (state)
                LOAD: state_n = wr_last ? HAND : LOAD;
                HAND: state_n = blk_ready ? HASH : HAND;
                HASH: state_n = core_done ? (blk_last ? OUT : LOAD) : HASH;
                OUT:  state_n = (fe_acc && fcnt == FCW'(ND - 1)) ? IDLE : OUT;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= 1'b0;
            err       <= 1'b0;
            core_init <= 1'b0;
            blk_last  <= 1'b0;
            odata     <= '0;
            wcnt      <= '0;
            fcnt      <= '0;
            dig_buf   <= '0;
        end else begin
            state     <= state_n;
            ack       <= ld_acc || fe_acc;
            core_init <= init;
            err       <= init ? 1'b0 : (err | stray);
            if (init) begin
                wcnt <= '0;
                fcnt <= '0;
            end else begin
                if (ld_acc) wcnt <= wcnt + 1'b1;
                if (wr_last) blk_last <= EOM;
                if (latch) begin
                    dig_buf <= digest;
                    fcnt    <= '0;
                end
                if (fe_acc) begin
                    odata <= dig_buf[IO_W*(ND-1-int'(fcnt)) +: IO_W];
                    fcnt  <= fcnt + 1'b1;
                end
            end
        end
    end
endmodule
